// File: rtl/muldiv_issue_pkg.sv
// Shared codes for the multiply/divide issuer: request kinds, unit op codes and FSM states.
package muldiv_issue_pkg;

    localparam logic [2:0] MDK_START = 3'd0;
    localparam logic [2:0] MDK_MFHI  = 3'd1;
    localparam logic [2:0] MDK_MFLO  = 3'd2;
    localparam logic [2:0] MDK_MTHI  = 3'd3;
    localparam logic [2:0] MDK_MTLO  = 3'd4;

    localparam logic [2:0] MDMUL  = 3'd0;
    localparam logic [2:0] MDMULU = 3'd1;
    localparam logic [2:0] MDDIV  = 3'd2;
    localparam logic [2:0] MDDIVU = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_WAIT_LO = 3'd6
    } md_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= MDDIVU;
    endfunction

    function automatic logic kind_legal(input logic [2:0] kind);
        return kind <= MDK_MTLO;
    endfunction

endpackage

// File: rtl/md_timeout_ctr.sv
// Saturating watchdog counter: counts while enabled, flags when it reaches TIMEOUT.
module md_timeout_ctr
    import muldiv_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_o
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired_o = (cnt_q == W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/muldiv_issue.sv
// Issuer for the multi-cycle MulDiv unit: launches mult/div, performs HI/LO reads and writes,
// stalls the core while the unit is busy and reports completion or errors.
module muldiv_issue
    import muldiv_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT        = 32,
    parameter bit          BLOCKING_START = 1'b0
) (
    input  logic        MDISSUE_clk,
    input  logic        MDISSUE_reset,
    input  logic        req_i,
    input  logic [2:0]  req_kind_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rd_data_o,
    output logic        md_start_o,
    output logic [2:0]  md_op_o,
    output logic [31:0] md_a_o,
    output logic [31:0] md_b_o,
    output logic        md_hl_src_o,
    output logic        md_hlwe_o,
    input  logic        md_busy_i,
    input  logic [31:0] md_hlrd_i,
    output logic [2:0]  dbg_state_o
);

    // Handshake: req_i is held with stable fields until done_o; stall_o = req_i && !done_o.
    // The request is released in the done_o cycle and never re-accepted in that same cycle.

    md_state_e   state_q, state_d;
    logic        inflight_q, inflight_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        md_start_q, md_start_d;
    logic [2:0]  md_op_q, md_op_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic        md_hl_src_q, md_hl_src_d;
    logic        md_hlwe_q, md_hlwe_d;
    logic        ctr_clr, ctr_en, ctr_expired;
    logic        can_accept;

    md_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk       (MDISSUE_clk),
        .reset     (MDISSUE_reset),
        .clr       (ctr_clr),
        .en        (ctr_en),
        .expired_o (ctr_expired)
    );

    assign can_accept = req_i && !done_q && !inflight_q && !md_busy_i;

    always_comb begin
        state_d     = state_q;
        inflight_d  = inflight_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        md_start_d  = 1'b0;
        md_op_d     = md_op_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        md_hl_src_d = md_hl_src_q;
        md_hlwe_d   = 1'b0;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (can_accept) begin
                    if (!kind_legal(req_kind_i) ||
                        (req_kind_i == MDK_START && !op_legal(req_op_i))) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (req_kind_i == MDK_START) begin
                        state_d    = ST_LAUNCH;
                        md_start_d = 1'b1;
                        md_op_d    = req_op_i;
                        md_a_d     = req_a_i;
                        md_b_d     = req_b_i;
                        done_d     = !BLOCKING_START;
                    end else if (req_kind_i == MDK_MFHI || req_kind_i == MDK_MFLO) begin
                        state_d     = ST_READ;
                        md_hl_src_d = (req_kind_i == MDK_MFHI);
                    end else begin
                        state_d     = ST_WRITE;
                        md_hlwe_d   = 1'b1;
                        md_hl_src_d = (req_kind_i == MDK_MTHI);
                        md_a_d      = req_a_i;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                inflight_d = 1'b1;
                ctr_clr    = 1'b1;
                state_d    = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                ctr_en = 1'b1;
                if (md_busy_i) begin
                    ctr_clr = 1'b1;
                    state_d = ST_WAIT_LO;
                end else if (ctr_expired) begin
                    err_d      = 1'b1;
                    inflight_d = 1'b0;
                    done_d     = BLOCKING_START;
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                ctr_en = 1'b1;
                // A blocking start completes here; a timeout still owes that pulse.
                if (!md_busy_i) begin
                    inflight_d = 1'b0;
                    done_d     = BLOCKING_START;
                    state_d    = ST_IDLE;
                end else if (ctr_expired) begin
                    err_d      = 1'b1;
                    inflight_d = 1'b0;
                    done_d     = BLOCKING_START;
                    state_d    = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_data_d = md_hlrd_i;
                done_d    = 1'b1;
                state_d   = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = ST_IDLE;
            ST_WRITE:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MDISSUE_clk) begin
        if (MDISSUE_reset) begin
            state_q     <= ST_IDLE;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            md_start_q  <= 1'b0;
            md_op_q     <= '0;
            md_a_q      <= '0;
            md_b_q      <= '0;
            md_hl_src_q <= 1'b0;
            md_hlwe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            md_start_q  <= md_start_d;
            md_op_q     <= md_op_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            md_hl_src_q <= md_hl_src_d;
            md_hlwe_q   <= md_hlwe_d;
        end
    end

    assign stall_o     = req_i && !done_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_data_o   = rd_data_q;
    assign md_start_o  = md_start_q;
    assign md_op_o     = md_op_q;
    assign md_a_o      = md_a_q;
    assign md_b_o      = md_b_q;
    assign md_hl_src_o = md_hl_src_q;
    assign md_hlwe_o   = md_hlwe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: two issuers (non-blocking and blocking start), each driving a small MulDiv model.
module tb_muldiv_issue;
    import muldiv_issue_pkg::*;

    localparam int TIMEOUT = 32;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam int BOUND   = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst = 2'b11;
    logic [1:0]       req = '0;
    logic [1:0][2:0]  req_kind = '0;
    logic [1:0][2:0]  req_op = '0;
    logic [1:0][31:0] req_a = '0;
    logic [1:0][31:0] req_b = '0;
    logic [1:0]       stall, done, err, md_start, md_hl_src, md_hlwe, md_busy;
    logic [1:0][2:0]  md_op, dbg_state;
    logic [1:0][31:0] rd_data, md_a, md_b, md_hlrd;

    logic [1:0]       force_busy = '0;
    logic [1:0]       busy_r;
    logic [1:0][31:0] hi_r, lo_r, res_hi, res_lo;
    int               cnt_r [2];
    int               hlwe_cnt [2];
    int               start_cnt [2];
    logic [1:0]       hlwe_bad = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    muldiv_issue #(.TIMEOUT(TIMEOUT), .BLOCKING_START(1'b0)) u_dut0 (
        .MDISSUE_clk(clk), .MDISSUE_reset(rst[0]), .req_i(req[0]), .req_kind_i(req_kind[0]),
        .req_op_i(req_op[0]), .req_a_i(req_a[0]), .req_b_i(req_b[0]), .stall_o(stall[0]),
        .done_o(done[0]), .err_o(err[0]), .rd_data_o(rd_data[0]), .md_start_o(md_start[0]),
        .md_op_o(md_op[0]), .md_a_o(md_a[0]), .md_b_o(md_b[0]), .md_hl_src_o(md_hl_src[0]),
        .md_hlwe_o(md_hlwe[0]), .md_busy_i(md_busy[0]), .md_hlrd_i(md_hlrd[0]),
        .dbg_state_o(dbg_state[0])
    );

    muldiv_issue #(.TIMEOUT(TIMEOUT), .BLOCKING_START(1'b1)) u_dut1 (
        .MDISSUE_clk(clk), .MDISSUE_reset(rst[1]), .req_i(req[1]), .req_kind_i(req_kind[1]),
        .req_op_i(req_op[1]), .req_a_i(req_a[1]), .req_b_i(req_b[1]), .stall_o(stall[1]),
        .done_o(done[1]), .err_o(err[1]), .rd_data_o(rd_data[1]), .md_start_o(md_start[1]),
        .md_op_o(md_op[1]), .md_a_o(md_a[1]), .md_b_o(md_b[1]), .md_hl_src_o(md_hl_src[1]),
        .md_hlwe_o(md_hlwe[1]), .md_busy_i(md_busy[1]), .md_hlrd_i(md_hlrd[1]),
        .dbg_state_o(dbg_state[1])
    );

    // ---------------- MulDiv unit model ----------------
    function automatic logic [63:0] md_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx, sy, sq, sr;
        sx = x;
        sy = y;
        case (o)
            MDMUL:   md_calc = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            MDMULU:  md_calc = {32'd0, x} * {32'd0, y};
            MDDIV: begin
                sq = sx / sy;
                sr = sx % sy;
                md_calc = {sr, sq};
            end
            default: md_calc = {x % y, x / y};
        endcase
    endfunction

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            md_busy[g] = busy_r[g] | force_busy[g];
            md_hlrd[g] = md_hl_src[g] ? hi_r[g] : lo_r[g];
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                busy_r[g] <= 1'b0;
                cnt_r[g]  <= 0;
                hi_r[g]   <= '0;
                lo_r[g]   <= '0;
                res_hi[g] <= '0;
                res_lo[g] <= '0;
            end else if (md_start[g]) begin
                busy_r[g] <= 1'b1;
                cnt_r[g]  <= ((md_op[g] == MDMUL || md_op[g] == MDMULU) ? MUL_LAT : DIV_LAT) - 1;
                {res_hi[g], res_lo[g]} <= md_calc(md_op[g], md_a[g], md_b[g]);
            end else if (busy_r[g]) begin
                if (cnt_r[g] == 0) begin
                    busy_r[g] <= 1'b0;
                    hi_r[g]   <= res_hi[g];
                    lo_r[g]   <= res_lo[g];
                end else begin
                    cnt_r[g] <= cnt_r[g] - 1;
                end
            end else if (md_hlwe[g]) begin
                if (md_hl_src[g]) hi_r[g] <= md_a[g];
                else              lo_r[g] <= md_a[g];
            end
        end
    end

    initial begin
        hlwe_cnt[0] = 0; hlwe_cnt[1] = 0;
        start_cnt[0] = 0; start_cnt[1] = 0;
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (md_hlwe[g]) hlwe_cnt[g] <= hlwe_cnt[g] + 1;
            if (md_start[g]) start_cnt[g] <= start_cnt[g] + 1;
            if (md_hlwe[g] && md_busy[g]) hlwe_bad[g] <= 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int u, input logic [2:0] k, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic st1, output logic [31:0] rdv);
        req[u] = 1'b1;
        req_kind[u] = k;
        req_op[u] = o;
        req_a[u] = x;
        req_b[u] = y;
        lat = 0;
        st1 = 1'b0;
        while (lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (lat == 1) st1 = stall[u];
            if (done[u]) break;
        end
        checks++;
        if (done[u] !== 1'b1) begin
            errors++;
            $display("FAIL issue_done u%0d kind=%0d: done_o=%b after %0d cycles, required 1", u, k, done[u], lat);
        end
        rdv = rd_data[u];
        req[u] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 2'b11;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({done[u], err[u], stall[u], md_start[u], md_hlwe[u], md_hl_src[u], md_op[u], dbg_state[u]} !== 12'd0) begin
                errors++;
                $display("FAIL reset_ctrl u%0d: got done=%b err=%b stall=%b start=%b hlwe=%b src=%b op=%0d state=%0d, required all 0",
                         u, done[u], err[u], stall[u], md_start[u], md_hlwe[u], md_hl_src[u], md_op[u], dbg_state[u]);
            end
            checks++;
            if ({md_a[u], md_b[u], rd_data[u]} !== 96'd0) begin
                errors++;
                $display("FAIL reset_data u%0d: got a=%h b=%h rd=%h, required 0", u, md_a[u], md_b[u], rd_data[u]);
            end
        end
        rst = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_mtlo_mflo();
        int lat, h0;
        logic st;
        logic [31:0] rdv, e;
        h0 = hlwe_cnt[0];
        issue(0, MDK_MTLO, MDMUL, 32'd5, 32'd0, lat, st, rdv);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL mtlo_latency: got %0d, required 1", lat); end
        @(negedge clk);
        exp_q.push_back(32'h0000_0005);
        issue(0, MDK_MFLO, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL mflo_latency: got %0d, required 2", lat); end
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL mflo_data: got %h, required %h", rdv, e); end
        @(negedge clk);
        checks++;
        if (hlwe_cnt[0] - h0 !== 1) begin errors++; $display("FAIL mtlo_hlwe_cycles: got %0d, required 1", hlwe_cnt[0] - h0); end
    endtask

    task automatic test_mul_read();
        int lat;
        logic st;
        logic [31:0] rdv, e;
        issue(0, MDK_START, MDMUL, 32'd7, 32'hFFFF_FFFD, lat, st, rdv);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL mul_nonblocking_done: got latency %0d, required 1", lat); end
        exp_q.push_back(32'hFFFF_FFFF);
        issue(0, MDK_MFHI, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL mfhi_stall: got stall_o=%b, required 1", st); end
        checks++;
        if (md_busy[0] !== 1'b0 || lat <= MUL_LAT) begin
            errors++;
            $display("FAIL mfhi_wait_busy: got busy=%b latency=%0d, required busy 0 and latency > %0d", md_busy[0], lat, MUL_LAT);
        end
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL mul_hi: got %h, required %h", rdv, e); end
        @(negedge clk);
        exp_q.push_back(32'hFFFF_FFEB);
        issue(0, MDK_MFLO, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL mul_lo: got %h, required %h", rdv, e); end
    endtask

    task automatic test_back_to_back();
        int lat, h0;
        logic st;
        logic [31:0] rdv, e;
        h0 = hlwe_cnt[0];
        issue(0, MDK_START, MDDIVU, 32'd100, 32'd7, lat, st, rdv);
        issue(0, MDK_MTHI, MDMUL, 32'h0000_00AA, 32'd0, lat, st, rdv);
        checks++;
        if (st !== 1'b1 || md_busy[0] !== 1'b0 || lat <= DIV_LAT) begin
            errors++;
            $display("FAIL mthi_held_off: got stall=%b busy=%b latency=%0d, required stall 1 busy 0 latency > %0d",
                     st, md_busy[0], lat, DIV_LAT);
        end
        @(negedge clk);
        checks++;
        if (hlwe_bad[0] !== 1'b0 || hlwe_cnt[0] - h0 !== 1) begin
            errors++;
            $display("FAIL mthi_hlwe: got hlwe_while_busy=%b pulses=%0d, required 0 and 1", hlwe_bad[0], hlwe_cnt[0] - h0);
        end
        exp_q.push_back(32'd14);
        issue(0, MDK_MFLO, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL divu_lo: got %h, required %h", rdv, e); end
        @(negedge clk);
        exp_q.push_back(32'h0000_00AA);
        issue(0, MDK_MFHI, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL mthi_readback: got %h, required %h", rdv, e); end
    endtask

    task automatic test_blocking();
        int lat;
        logic st;
        logic [31:0] rdv, e;
        issue(1, MDK_START, MDDIV, 32'hFFFF_FFF9, 32'd2, lat, st, rdv);
        checks++;
        if (lat !== DIV_LAT + 3 || md_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL blocking_done: got latency=%0d busy=%b, required latency %0d busy 0", lat, md_busy[1], DIV_LAT + 3);
        end
        @(negedge clk);
        exp_q.push_back(32'hFFFF_FFFD);
        issue(1, MDK_MFLO, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL div_lo: got %h, required %h", rdv, e); end
        @(negedge clk);
        exp_q.push_back(32'hFFFF_FFFF);
        issue(1, MDK_MFHI, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e) begin errors++; $display("FAIL div_hi: got %h, required %h", rdv, e); end
    endtask

    task automatic test_illegal();
        int lat, s0;
        logic st;
        logic [31:0] rdv;
        @(negedge clk);
        s0 = start_cnt[0];
        issue(0, MDK_START, 3'b111, 32'd1, 32'd1, lat, st, rdv);
        checks++;
        if (lat !== 1 || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: got latency=%0d err=%b, required 1 and 1", lat, err[0]);
        end
        @(negedge clk);
        checks++;
        if (start_cnt[0] !== s0 || dbg_state[0] !== ST_IDLE) begin
            errors++;
            $display("FAIL illegal_op_no_start: got start pulses=%0d state=%0d, required 0 and %0d", start_cnt[0] - s0, dbg_state[0], ST_IDLE);
        end
        issue(1, 3'b101, MDMUL, 32'd1, 32'd1, lat, st, rdv);
        checks++;
        if (lat !== 1 || err[1] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_kind: got latency=%0d err=%b, required 1 and 1", lat, err[1]);
        end
    endtask

    task automatic test_timeout();
        int lat, k;
        logic st;
        logic [31:0] rdv;
        rst = 2'b11;
        repeat (2) @(negedge clk);
        rst = 2'b00;
        @(negedge clk);
        checks++;
        if (err[0] !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b, required 0", err[0]); end
        issue(0, MDK_START, MDMUL, 32'd3, 32'd4, lat, st, rdv);
        force_busy[0] = 1'b1;
        k = 0;
        while (k < 100 && err[0] !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (err[0] !== 1'b1 || k < TIMEOUT || k > TIMEOUT + 4) begin
            errors++;
            $display("FAIL timeout_err: got err=%b after %0d cycles, required err 1 within %0d..%0d", err[0], k, TIMEOUT, TIMEOUT + 4);
        end
        force_busy[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state[0] !== ST_IDLE) begin errors++; $display("FAIL timeout_idle: got state %0d, required %0d", dbg_state[0], ST_IDLE); end
    endtask

    task automatic test_reset_mid_divide();
        int lat;
        logic st;
        logic [31:0] rdv, e;
        issue(0, MDK_START, MDDIVU, 32'd1000, 32'd3, lat, st, rdv);
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({done[0], err[0], stall[0], md_start[0], md_hlwe[0], md_hl_src[0], md_op[0], dbg_state[0]} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got done=%b err=%b start=%b hlwe=%b src=%b op=%0d state=%0d, required all 0",
                     done[0], err[0], md_start[0], md_hlwe[0], md_hl_src[0], md_op[0], dbg_state[0]);
        end
        checks++;
        if ({md_a[0], md_b[0], rd_data[0]} !== 96'd0) begin
            errors++;
            $display("FAIL midreset_data: got a=%h b=%h rd=%h, required 0", md_a[0], md_b[0], rd_data[0]);
        end
        rst[0] = 1'b0;
        @(negedge clk);
        issue(0, MDK_MTLO, MDMUL, 32'h0000_1234, 32'd0, lat, st, rdv);
        @(negedge clk);
        exp_q.push_back(32'h0000_1234);
        issue(0, MDK_MFLO, MDMUL, 32'd0, 32'd0, lat, st, rdv);
        e = exp_q.pop_front();
        checks++;
        if (rdv !== e || lat !== 2) begin
            errors++;
            $display("FAIL midreset_roundtrip: got %h latency %0d, required %h latency 2", rdv, lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_mtlo_mflo();
        test_mul_read();
        test_back_to_back();
        test_blocking();
        test_illegal();
        test_timeout();
        test_reset_mid_divide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
